// File: rtl/z16_pkg.sv
// Shared definitions for the Z16 execute stage: widths, opcodes, instruction
// layout and the sequencer state encoding.
package z16_pkg;
    localparam int DW   = 16;
    localparam int NREG = 16;
    localparam int AW   = $clog2(NREG);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'hF;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
    } instr_t;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WB} state_t;

    function automatic logic is_reserved(input logic [3:0] op);
        return !(op == OP_ADD || op == OP_SUB || op == OP_MUL ||
                 op == OP_DIV || op == OP_OR  || op == OP_LDI);
    endfunction
endpackage

// File: rtl/z16_alu_seq_if.sv
// Instruction handshake, ALU operand/result, writeback and debug signals of the
// sequencer; names are from the sequencer's point of view.
interface z16_alu_seq_if;
    import z16_pkg::*;

    logic          i_instr_valid;
    logic          o_instr_ready;
    logic [15:0]   i_instr;
    logic [DW-1:0] o_alu_a;
    logic [DW-1:0] o_alu_b;
    logic [3:0]    o_alu_ctrl;
    logic [DW-1:0] i_alu_result;
    logic          o_wb_valid;
    logic [3:0]    o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic          o_err;
    logic [3:0]    i_dbg_addr;
    logic [DW-1:0] o_dbg_data;

    modport master (
        output i_instr_valid, i_instr, i_alu_result, i_dbg_addr,
        input  o_instr_ready, o_alu_a, o_alu_b, o_alu_ctrl,
               o_wb_valid, o_wb_addr, o_wb_data, o_err, o_dbg_data
    );

    modport slave (
        input  i_instr_valid, i_instr, i_alu_result, i_dbg_addr,
        output o_instr_ready, o_alu_a, o_alu_b, o_alu_ctrl,
               o_wb_valid, o_wb_addr, o_wb_data, o_err, o_dbg_data
    );
endinterface

// File: rtl/z16_alu.sv
// Combinational Z16 ALU: ADD/SUB/MUL/DIV/OR on DW-bit operands, low DW bits kept.
// Divide by zero yields 0; the sequencer substitutes its own value in that case.
module Z16ALU
    import z16_pkg::*;
(
    input  logic [DW-1:0] i_data_a,
    input  logic [DW-1:0] i_data_b,
    input  logic [3:0]    i_ctrl,
    output logic [DW-1:0] o_data
);
    always_comb begin
        o_data = '0;
        case (i_ctrl)
            OP_ADD:  o_data = i_data_a + i_data_b;
            OP_SUB:  o_data = i_data_a - i_data_b;
            OP_MUL:  o_data = i_data_a * i_data_b;
            OP_DIV:  o_data = (i_data_b == '0) ? '0 : i_data_a / i_data_b;
            OP_OR:   o_data = i_data_a | i_data_b;
            default: o_data = '0;
        endcase
    end
endmodule

// File: rtl/z16_regfile.sv
// NREG x DW register file: two read ports latched on rd_en, one write port,
// one combinational debug read; R0 always reads 0 and ignores writes.
module z16_regfile
    import z16_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);
    logic [DW-1:0] mem [NREG];

    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
            rd_a <= '0;
            rd_b <= '0;
        end else begin
            if (we && wa != '0) mem[wa] <= wd;
            if (rd_en) begin
                rd_a <= (ra == '0) ? '0 : mem[ra];
                rd_b <= (rb == '0) ? '0 : mem[rb];
            end
        end
    end
endmodule

// File: rtl/z16_alu_seq.sv
// Instruction sequencer in front of Z16ALU: IDLE->READ->EXEC->WB, writeback pulse
// 3 cycles after accept; ready only in IDLE, so valid is ignored while busy.
module z16_alu_seq
    import z16_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    z16_alu_seq_if.slave  bus
);
    state_t state;
    instr_t ir;
    logic   rd_en;

    assign rd_en = (state == ST_READ);

    // The register write lands on the edge that ends WB, so a debug read
    // during WB still shows the old value.
    z16_regfile u_rf (
        .clk      (i_clk),
        .rst      (i_rst),
        .rd_en    (rd_en),
        .ra       (ir.ra),
        .rb       (ir.rb),
        .rd_a     (bus.o_alu_a),
        .rd_b     (bus.o_alu_b),
        .we       (bus.o_wb_valid),
        .wa       (bus.o_wb_addr),
        .wd       (bus.o_wb_data),
        .dbg_addr (bus.i_dbg_addr),
        .dbg_data (bus.o_dbg_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= ST_IDLE;
            ir                <= '0;
            bus.o_instr_ready <= 1'b1;
            bus.o_alu_ctrl    <= '0;
            bus.o_wb_valid    <= 1'b0;
            bus.o_wb_addr     <= '0;
            bus.o_wb_data     <= '0;
            bus.o_err         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_instr_valid && bus.o_instr_ready) begin
                        ir                <= bus.i_instr;
                        bus.o_instr_ready <= 1'b0;
                        state             <= ST_READ;
                    end
                end
                ST_READ: begin
                    bus.o_alu_ctrl <= ir.op;
                    state          <= ST_EXEC;
                end
                ST_EXEC: begin
                    state <= ST_WB;
                    if (is_reserved(ir.op)) begin
                        bus.o_err <= 1'b1;
                    end else begin
                        bus.o_wb_valid <= 1'b1;
                        bus.o_wb_addr  <= ir.rd;
                        if (ir.op == OP_LDI) begin
                            bus.o_wb_data <= DW'({ir.ra, ir.rb});
                        end else if (ir.op == OP_DIV && bus.o_alu_b == '0) begin
                            bus.o_wb_data <= '1;
                            bus.o_err     <= 1'b1;
                        end else begin
                            bus.o_wb_data <= bus.i_alu_result;
                        end
                    end
                end
                ST_WB: begin
                    bus.o_wb_valid    <= 1'b0;
                    bus.o_instr_ready <= 1'b1;
                    state             <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
